// File: rtl/ika2151_noise_gen.sv
// ika2151_noise_gen -- YM2151-style noise generator.
// A 5-bit frequency counter, advanced in the counter slot, raises a step
// request. The request is consumed in the step slot, where the 17-bit XNOR
// LFSR shifts once and its new bit 0 becomes the noise output. State changes
// only on ticks, meaning EMUCLK edges with the active-low phi1 enable low.
// Optional build macro: IKA2151_NOISE_TEST_EN adds i_TEST_FORCE_STEP, which
// forces an LFSR step in the step slot without disturbing cnt or step_req.
module ika2151_noise_gen (
    input  logic       i_EMUCLK,
    input  logic       i_MRST,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_CYCLE_12,
    input  logic       i_CYCLE_15_31,
    input  logic       i_NE,
    input  logic [4:0] i_NFRQ,
`ifdef IKA2151_NOISE_TEST_EN
    input  logic       i_TEST_FORCE_STEP,
`endif
    output logic       o_NOISE,
    output logic       o_NOISE_EN,
    output logic       o_NOISE_STEP
);

    logic        tick;
    logic        force_step;
    logic        cnt_match;
    logic        step_fire;
    logic [16:0] lfsr_shift;

    logic [4:0]  cnt_q, cnt_d;
    logic        step_req_q, step_req_d;
    logic [16:0] lfsr_q, lfsr_d;
    logic        noise_q, noise_d;
    logic        noise_en_q, noise_en_d;
    logic        noise_step_q, noise_step_d;

    assign tick = ~i_phi1_NCEN_n;

`ifdef IKA2151_NOISE_TEST_EN
    assign force_step = i_TEST_FORCE_STEP;
`else
    assign force_step = 1'b0;
`endif

    // The counter target is the ones-complement of NFRQ: NFRQ=31 matches at
    // cnt=0 (every strobe), and NFRQ=0 matches at cnt=31 (every 32 strobes).
    assign cnt_match  = (cnt_q == (5'h1F ^ i_NFRQ));
    assign step_fire  = i_CYCLE_12 & (step_req_q | force_step);
    // XNOR feedback keeps the all-zero reset state live; all-ones is the
    // lock-up state, and it cannot be reached from reset.
    assign lfsr_shift = {lfsr_q[0] ~^ lfsr_q[3], lfsr_q[16:1]};

    // Next-state logic. Everything holds unless this edge is a tick.
    always_comb begin
        cnt_d        = cnt_q;
        step_req_d   = step_req_q;
        lfsr_d       = lfsr_q;
        noise_d      = noise_q;
        noise_en_d   = noise_en_q;
        noise_step_d = noise_step_q;
        if (tick) begin
            if (i_CYCLE_12) begin
                // A forced step leaves a pending request alone; only a real
                // request is consumed here.
                if (step_req_q) step_req_d = 1'b0;
                if (step_fire)  lfsr_d     = lfsr_shift;
                noise_d      = step_fire ? lfsr_shift[0] : lfsr_q[0];
                noise_en_d   = i_NE;
                noise_step_d = step_fire;
            end else begin
                noise_step_d = 1'b0;
            end
            // A match in the same tick as a consuming step comes last, so the
            // new request survives.
            if (i_CYCLE_15_31) begin
                if (cnt_match) begin
                    cnt_d      = 5'd0;
                    step_req_d = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 5'd1;
                end
            end
        end
    end

    // State registers with asynchronous reset; a reset drops any pending step.
    always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
        if (i_MRST) begin
            cnt_q        <= 5'd0;
            step_req_q   <= 1'b0;
            lfsr_q       <= 17'h00000;
            noise_q      <= 1'b0;
            noise_en_q   <= 1'b0;
            noise_step_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            step_req_q   <= step_req_d;
            lfsr_q       <= lfsr_d;
            noise_q      <= noise_d;
            noise_en_q   <= noise_en_d;
            noise_step_q <= noise_step_d;
        end
    end

    assign o_NOISE      = noise_q;
    assign o_NOISE_EN   = noise_en_q;
    assign o_NOISE_STEP = noise_step_q;

endmodule

// File: tb/tb_ika2151_noise_gen.sv
// tb_ika2151_noise_gen -- self-checking bench for ika2151_noise_gen.
// Frame timing: 32 tick slots, step slot 11, counter slots 14 and 30.
module tb_ika2151_noise_gen;

    logic       i_EMUCLK = 1'b0;
    logic       i_MRST = 1'b1;
    logic       i_phi1_NCEN_n = 1'b1;
    logic       i_CYCLE_12 = 1'b0;
    logic       i_CYCLE_15_31 = 1'b0;
    logic       i_NE = 1'b0;
    logic [4:0] i_NFRQ = 5'd31;
    logic       i_TEST_FORCE_STEP = 1'b0;
    logic       o_NOISE, o_NOISE_EN, o_NOISE_STEP;

    ika2151_noise_gen dut (
        .i_EMUCLK          (i_EMUCLK),
        .i_MRST            (i_MRST),
        .i_phi1_NCEN_n     (i_phi1_NCEN_n),
        .i_CYCLE_12        (i_CYCLE_12),
        .i_CYCLE_15_31     (i_CYCLE_15_31),
        .i_NE              (i_NE),
        .i_NFRQ            (i_NFRQ),
`ifdef IKA2151_NOISE_TEST_EN
        .i_TEST_FORCE_STEP (i_TEST_FORCE_STEP),
`endif
        .o_NOISE           (o_NOISE),
        .o_NOISE_EN        (o_NOISE_EN),
        .o_NOISE_STEP      (o_NOISE_STEP)
    );

    always #5 i_EMUCLK = ~i_EMUCLK;

    int checks = 0;
    int failures = 0;
    int slot = 0;

    // Reference model: counter as an integer counting toward 31-NFRQ, LFSR
    // as a bit queue with element 0 = the output end.
    int m_cnt;
    bit m_req;
    bit m_lfsr[$];
    bit m_noise, m_en, m_step;

    function automatic void model_reset();
        m_cnt = 0;
        m_req = 0;
        m_lfsr.delete();
        for (int i = 0; i < 17; i++) m_lfsr.push_back(1'b0);
        m_noise = 0;
        m_en = 0;
        m_step = 0;
    endfunction

    function automatic logic [16:0] m_val();
        logic [16:0] v;
        v = '0;
        for (int i = 0; i < 17; i++) v[i] = m_lfsr[i];
        return v;
    endfunction

    function automatic void model_tick();
        bit fire, new_req, nb;
        fire    = i_CYCLE_12 && (m_req || i_TEST_FORCE_STEP);
        new_req = m_req;
        if (i_CYCLE_12 && m_req) new_req = 0;
        if (i_CYCLE_15_31) begin
            if (m_cnt == 31 - int'(i_NFRQ)) begin
                m_cnt = 0;
                new_req = 1;
            end else begin
                m_cnt = (m_cnt + 1) % 32;
            end
        end
        if (fire) begin
            nb = !(m_lfsr[0] ^ m_lfsr[3]);
            void'(m_lfsr.pop_front());
            m_lfsr.push_back(nb);
        end
        if (i_CYCLE_12) begin
            m_noise = m_lfsr[0];
            m_en    = i_NE;
            m_step  = fire;
        end else begin
            m_step = 0;
        end
        m_req = new_req;
    endfunction

    // One EMUCLK cycle; tk selects a tick, rs selects random strobes instead
    // of the slot-derived ones. Inputs change 1 time unit after the edge.
    task automatic clk_cycle(input bit tk, input bit rs);
        i_phi1_NCEN_n = !tk;
        if (rs) begin
            i_CYCLE_12    = ($urandom % 3) == 0;
            i_CYCLE_15_31 = ($urandom % 3) == 0;
        end else begin
            i_CYCLE_12    = (slot == 11);
            i_CYCLE_15_31 = (slot == 14) || (slot == 30);
        end
        @(posedge i_EMUCLK);
        if (tk && !i_MRST) model_tick();
        #1;
        if (tk) slot = (slot + 1) % 32;
    endtask

    task automatic apply_reset(input int n);
        i_MRST = 1'b1;
        repeat (n) clk_cycle(1'b1, 1'b0);
        i_MRST = 1'b0;
        model_reset();
        slot = 0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) clk_cycle(1'b1, 1'b0);
        checks++;
        if ({o_NOISE, o_NOISE_EN, o_NOISE_STEP} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs got %b exp 000", {o_NOISE, o_NOISE_EN, o_NOISE_STEP});
        end
        checks++;
        if (dut.lfsr_q !== 17'h00000 || dut.cnt_q !== 5'd0 || dut.step_req_q !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got lfsr=%h cnt=%0d req=%b exp 0/0/0", dut.lfsr_q, dut.cnt_q, dut.step_req_q);
        end
        i_MRST = 1'b0;
        model_reset();
        slot = 0;
    endtask

    // NFRQ=31: first step lands in slot 11 of frame 1, then one per frame
    // (the second match of each frame finds the request already pending).
    task automatic test_first_step();
        int pulses;
        i_NFRQ = 5'd31;
        i_NE = 1'b0;
        for (int i = 0; i < 44; i++) begin
            clk_cycle(1'b1, 1'b0);
            checks++;
            if (o_NOISE_STEP !== (i == 43)) begin
                failures++;
                $display("FAIL first_step tick=%0d got %b exp %b", i, o_NOISE_STEP, (i == 43));
            end
        end
        checks++;
        if (dut.lfsr_q !== 17'h10000 || o_NOISE !== 1'b0) begin
            failures++;
            $display("FAIL first_lfsr got lfsr=%h noise=%b exp 10000/0", dut.lfsr_q, o_NOISE);
        end
        pulses = 0;
        for (int i = 0; i < 128; i++) begin
            clk_cycle(1'b1, 1'b0);
            if (o_NOISE_STEP === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 4) begin
            failures++;
            $display("FAIL steps_per_frame got %0d exp 4", pulses);
        end
        checks++;
        if (dut.lfsr_q !== m_val()) begin
            failures++;
            $display("FAIL lfsr_after_5 got %h exp %h", dut.lfsr_q, m_val());
        end
    endtask

    task automatic test_seventeen();
        int steps;
        apply_reset(2);
        i_NFRQ = 5'd31;
        steps = 0;
        for (int i = 0; i < 600; i++) begin
            clk_cycle(1'b1, 1'b0);
            if (o_NOISE_STEP === 1'b1) steps++;
            checks++;
            if (o_NOISE !== (steps >= 17)) begin
                failures++;
                $display("FAIL noise_17 tick=%0d steps=%0d got %b exp %b", i, steps, o_NOISE, (steps >= 17));
            end
        end
        checks++;
        if (steps != 18) begin
            failures++;
            $display("FAIL steps_600 got %0d exp 18", steps);
        end
    endtask

    task automatic test_nfrq0();
        int first, second, np;
        apply_reset(2);
        i_NFRQ = 5'd0;
        first = -1;
        second = -1;
        np = 0;
        for (int i = 0; i < 1100; i++) begin
            clk_cycle(1'b1, 1'b0);
            if (o_NOISE_STEP === 1'b1) begin
                if (np == 0) first = i;
                if (np == 1) second = i;
                np++;
            end
        end
        checks++;
        if (np != 2 || first != 523 || second != 1035) begin
            failures++;
            $display("FAIL nfrq0_period got n=%0d at %0d,%0d exp n=2 at 523,1035", np, first, second);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(2);
        i_NFRQ = 5'd31;
        i_NE = 1'b1;
        repeat (66) clk_cycle(1'b1, 1'b0);
        checks++;
        if (dut.step_req_q !== 1'b1 || o_NOISE_EN !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got req=%b en=%b exp 1/1", dut.step_req_q, o_NOISE_EN);
        end
        i_MRST = 1'b1;
        #1;
        checks++;
        if ({o_NOISE, o_NOISE_EN, o_NOISE_STEP} !== 3'b000 || dut.step_req_q !== 1'b0 || dut.lfsr_q !== 17'h0) begin
            failures++;
            $display("FAIL async_reset got out=%b req=%b lfsr=%h exp 000/0/0",
                     {o_NOISE, o_NOISE_EN, o_NOISE_STEP}, dut.step_req_q, dut.lfsr_q);
        end
        repeat (3) clk_cycle(1'b1, 1'b0);
        i_MRST = 1'b0;
        model_reset();
        checks++;
        if (dut.cnt_q !== 5'd0 || slot != 5) begin
            failures++;
            $display("FAIL post_reset_cnt got cnt=%0d slot=%0d exp 0/5", dut.cnt_q, slot);
        end
        for (int i = 0; i < 39; i++) begin
            clk_cycle(1'b1, 1'b0);
            checks++;
            if (o_NOISE_STEP !== (i == 38)) begin
                failures++;
                $display("FAIL reset_no_step tick=%0d got %b exp %b", i, o_NOISE_STEP, (i == 38));
            end
        end
    endtask

    task automatic test_hold();
        logic [2:0]  s_out;
        logic [16:0] s_lfsr;
        logic [4:0]  s_cnt;
        logic        s_req;
        i_NE = 1'b0;
        repeat (32) clk_cycle(1'b1, 1'b0);
        s_out  = {o_NOISE, o_NOISE_EN, o_NOISE_STEP};
        s_lfsr = dut.lfsr_q;
        s_cnt  = dut.cnt_q;
        s_req  = dut.step_req_q;
        i_NE = 1'b1;
        for (int i = 0; i < 100; i++) begin
            i_NFRQ = 5'($urandom);
            clk_cycle(1'b0, 1'b1);
            checks++;
            if ({o_NOISE, o_NOISE_EN, o_NOISE_STEP} !== s_out || dut.lfsr_q !== s_lfsr ||
                dut.cnt_q !== s_cnt || dut.step_req_q !== s_req) begin
                failures++;
                $display("FAIL hold cyc=%0d got out=%b lfsr=%h cnt=%0d req=%b exp %b/%h/%0d/%b", i,
                         {o_NOISE, o_NOISE_EN, o_NOISE_STEP}, dut.lfsr_q, dut.cnt_q, dut.step_req_q,
                         s_out, s_lfsr, s_cnt, s_req);
            end
        end
        i_NFRQ = 5'd31;
        for (int i = 0; i < 32; i++) begin
            clk_cycle(1'b1, 1'b0);
            checks++;
            if (o_NOISE_EN !== (i == 31)) begin
                failures++;
                $display("FAIL ne_latch tick=%0d got %b exp %b", i, o_NOISE_EN, (i == 31));
            end
        end
    endtask

    // Random NFRQ/NE, gapped ticks, and stretches of random strobes (which
    // include both strobes in one tick) checked against the model.
    task automatic test_random();
        bit rs;
        apply_reset(2);
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) i_NFRQ = 5'($urandom);
            if (i % 16 == 0) i_NE = 1'($urandom);
            rs = ((i / 500) % 2) == 1;
`ifdef IKA2151_NOISE_TEST_EN
            i_TEST_FORCE_STEP = ($urandom % 8) == 0;
`endif
            clk_cycle(($urandom % 4) != 0, rs);
            checks++;
            if ({o_NOISE, o_NOISE_EN, o_NOISE_STEP} !== {m_noise, m_en, m_step} || dut.lfsr_q !== m_val()) begin
                failures++;
                $display("FAIL random cyc=%0d got out=%b lfsr=%h exp %b/%h", i,
                         {o_NOISE, o_NOISE_EN, o_NOISE_STEP}, dut.lfsr_q, {m_noise, m_en, m_step}, m_val());
            end
        end
        i_TEST_FORCE_STEP = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_seventeen();
        test_nfrq0();
        test_reset_mid();
        test_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
